// File: rtl/ir_receiver_pkg.sv
// Shared definitions for the IR command receiver: FSM encoding, register map
// and the microsecond acceptance windows for start and data marks.
package ir_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_MARK = 3'd1,
    SPACE      = 3'd2,
    DATA_MARK  = 3'd3,
    DONE       = 3'd4
  } ir_state_t;

  localparam logic [7:0] DATA_OFS   = 8'd0;
  localparam logic [7:0] STATUS_OFS = 8'd1;

  localparam int STAT_ERR_BIT   = 0;
  localparam int STAT_BUSY_BIT  = 1;
  localparam int STAT_VALID_BIT = 2;

  localparam int DUR_W = 12;

  localparam logic [DUR_W-1:0] START_MIN_US = 12'd1500;
  localparam logic [DUR_W-1:0] START_MAX_US = 12'd2500;
  localparam logic [DUR_W-1:0] ONE_MIN_US   = 12'd750;
  localparam logic [DUR_W-1:0] ONE_MAX_US   = 12'd1250;
  localparam logic [DUR_W-1:0] ZERO_MIN_US  = 12'd375;
  localparam logic [DUR_W-1:0] ZERO_MAX_US  = 12'd625;

  function automatic logic in_window(input logic [DUR_W-1:0] d,
                                     input logic [DUR_W-1:0] lo,
                                     input logic [DUR_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Conditions the IR input and times the current mark/space in microseconds.
// Optional majority filter enabled by IR_RECEIVER_GLITCH_FILTER_EN.
module ir_pulse_timer
  import ir_receiver_pkg::*;
#(
  parameter int CLK_PER_US = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ir_in,
  output logic             rise,
  output logic             fall,
  output logic [DUR_W-1:0] duration
);

  logic        sync1, sync2;
  logic        level, level_d;
  logic [15:0] pre;
  logic        tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
    end
  end

`ifdef IR_RECEIVER_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // A single-sample excursion is outvoted by its two neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync2};
      filt <= (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b1;
    else        level_d <= level;
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;
  assign tick = (pre == 16'(CLK_PER_US - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      duration <= '0;
    else if (rise || fall)           duration <= '0;
    else if (tick && duration != '1) duration <= duration + 1'b1;
  end

endmodule

// File: rtl/ir_receiver.sv
// Bus-mapped IR command receiver: decodes 4-bit frames, latches CMD, raises IRQ.
// Build option: IR_RECEIVER_GLITCH_FILTER_EN (input majority filter).
module ir_receiver
  import ir_receiver_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hB0,
  parameter int         CLK_PER_US = 50,
  parameter int         TIMEOUT_US = 2500
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic       IR_IN,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  logic             rise, fall;
  logic [DUR_W-1:0] duration;
  ir_state_t        state, state_next;
  logic [1:0]       bit_cnt;
  logic [3:0]       shift, cmd;
  logic             valid, ovr, err;
  logic             shift_en, set_err, done;
  logic             start_ok, is_one, is_zero, bit_ok, timeout;
  logic             rd_data, rd_status, wr_status;
  logic             out_en;
  logic [7:0]       out_data, data_word, status_word;

  ir_pulse_timer #(.CLK_PER_US(CLK_PER_US)) u_timer (
    .clk      (CLK),
    .rst_n    (RESET),
    .ir_in    (IR_IN),
    .rise     (rise),
    .fall     (fall),
    .duration (duration)
  );

  assign start_ok = in_window(duration, START_MIN_US, START_MAX_US);
  assign is_one   = in_window(duration, ONE_MIN_US, ONE_MAX_US);
  assign is_zero  = in_window(duration, ZERO_MIN_US, ZERO_MAX_US);
  assign bit_ok   = is_one | is_zero;
  assign timeout  = duration > DUR_W'(TIMEOUT_US);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (fall) state_next = START_MARK;
      START_MARK: if (rise) state_next = start_ok ? SPACE : IDLE;
      SPACE: begin
        if (fall)         state_next = DATA_MARK;
        else if (timeout) state_next = IDLE;
      end
      DATA_MARK: begin
        if (rise) begin
          if (!bit_ok)              state_next = IDLE;
          else if (bit_cnt == 2'd3) state_next = DONE;
          else                      state_next = SPACE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    set_err  = 1'b0;
    done     = 1'b0;
    case (state)
      START_MARK: set_err = rise & ~start_ok;
      SPACE:      set_err = ~fall & timeout;
      DATA_MARK: begin
        shift_en = rise & bit_ok;
        set_err  = rise & ~bit_ok;
      end
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Bits arrive LSB first, so shift in from the top.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 2'd1;
      if (shift_en)       shift <= {is_one, shift[3:1]};
    end
  end

  assign rd_data     = (BUS_ADDR == BASE_ADDR + DATA_OFS) && !BUS_WE;
  assign rd_status   = (BUS_ADDR == BASE_ADDR + STATUS_OFS) && !BUS_WE;
  assign wr_status   = (BUS_ADDR == BASE_ADDR + STATUS_OFS) && BUS_WE;
  assign data_word   = {valid, ovr, 2'b00, cmd};
  assign status_word = {5'b0, valid, (state != IDLE), err};

  // A completing frame outranks a same-cycle read-clear; the read consumed the old CMD.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cmd                 <= '0;
      valid               <= 1'b0;
      ovr                 <= 1'b0;
      err                 <= 1'b0;
      BUS_INTERRUPT_RAISE <= 1'b0;
      out_en              <= 1'b0;
      out_data            <= '0;
    end else begin
      if (done) cmd <= shift;
      valid               <= done | (valid & ~rd_data);
      ovr                 <= done ? (valid & ~rd_data) : (ovr & ~rd_data);
      err                 <= set_err | (err & ~wr_status);
      BUS_INTERRUPT_RAISE <= done | (BUS_INTERRUPT_RAISE & ~BUS_INTERRUPT_ACK);
      out_en              <= rd_data | rd_status;
      out_data            <= rd_data ? data_word : status_word;
    end
  end

  assign BUS_DATA = out_en ? out_data : 8'hzz;

endmodule

// File: tb/tb_ir_receiver.sv
// Scenario bench for ir_receiver; expected bus reads are queued with the stimulus.
// Honours IR_RECEIVER_GLITCH_FILTER_EN for latency and glitch expectations.
module tb_ir_receiver;

`ifdef IR_RECEIVER_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif
  localparam logic [7:0] DATA_ADDR = 8'hB0;
  localparam logic [7:0] STAT_ADDR = 8'hB1;
  localparam logic [7:0] IDLE_ADDR = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_addr;
  wire  [7:0] bus_data;
  logic       bus_we;
  logic       ir_in;
  logic       raise;
  logic       ack;
  logic       drv_en;
  logic [7:0] drv_val;

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  assign bus_data = drv_en ? drv_val : 8'hzz;

  ir_receiver #(.BASE_ADDR(8'hB0), .CLK_PER_US(1), .TIMEOUT_US(2500)) dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .BUS_ADDR            (bus_addr),
    .BUS_DATA            (bus_data),
    .BUS_WE              (bus_we),
    .IR_IN               (ir_in),
    .BUS_INTERRUPT_RAISE (raise),
    .BUS_INTERRUPT_ACK   (ack)
  );

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] val);
    bus_addr = addr;
    bus_we   = 1'b0;
    @(negedge clk);
    val      = bus_data;
    bus_addr = IDLE_ADDR;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] val);
    bus_addr = addr;
    bus_we   = 1'b1;
    drv_en   = 1'b1;
    drv_val  = val;
    @(negedge clk);
    bus_we   = 1'b0;
    drv_en   = 1'b0;
    bus_addr = IDLE_ADDR;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Drives a whole frame; returns right after the rise that ends bit 3.
  task automatic send_frame(input logic [3:0] cmd, input int start_len, input int one_len,
                            input int zero_len, input int sp_len, input int glitch_bit);
    ir_in = 1'b0;
    idle(start_len);
    for (int b = 0; b < 4; b++) begin
      ir_in = 1'b1;
      if (b == glitch_bit) begin
        idle(sp_len / 2);
        ir_in = 1'b0;
        @(negedge clk);
        ir_in = 1'b1;
        idle(sp_len / 2);
      end else begin
        idle(sp_len);
      end
      ir_in = 1'b0;
      idle(cmd[b] ? one_len : zero_len);
    end
    ir_in = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v, e;
    n_checks++;
    if (raise !== 1'b0) $display("FAIL reset_raise: got %b want 0", raise);
    else n_pass++;
    exp_q.push_back(8'h00);
    bus_read(DATA_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL reset_data: got %h want %h", v, e);
    else n_pass++;
    exp_q.push_back(8'h00);
    bus_read(STAT_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL reset_status: got %h want %h", v, e);
    else n_pass++;
    $display("reset: data/status read back after reset");
  endtask

  task automatic test_valid_frame();
    logic [7:0] v, e;
    send_frame(4'hD, 2000, 1000, 500, 500, -1);
    exp_q.push_back(8'h8D);
    exp_q.push_back(8'h0D);
    idle(LAT - 1);
    n_checks++;
    if (raise !== 1'b0) $display("FAIL valid_raise_early: got %b want 0", raise);
    else n_pass++;
    idle(1);
    n_checks++;
    if (raise !== 1'b1) $display("FAIL valid_raise_latency: got %b want 1", raise);
    else n_pass++;
    bus_read(STAT_ADDR, v);
    n_checks++;
    if (v !== 8'h04) $display("FAIL valid_status: got %h want 04", v);
    else n_pass++;
    pulse_ack();
    n_checks++;
    if (raise !== 1'b0) $display("FAIL valid_ack: got %b want 0", raise);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      bus_read(DATA_ADDR, v);
      e = exp_q.pop_front();
      n_checks++;
      if (v !== e) $display("FAIL valid_data%0d: got %h want %h", i, v, e);
      else n_pass++;
    end
    $display("valid_frame: cmd D decoded");
  endtask

  task automatic test_overrun();
    logic [7:0] v, e;
    send_frame(4'h3, 1600, 800, 400, 100, -1);
    idle(LAT + 2);
    send_frame(4'h5, 1600, 800, 400, 100, -1);
    exp_q.push_back(8'hC5);
    exp_q.push_back(8'h05);
    idle(LAT + 2);
    n_checks++;
    if (raise !== 1'b1) $display("FAIL ovr_raise_held: got %b want 1", raise);
    else n_pass++;
    bus_read(DATA_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL ovr_data: got %h want %h", v, e);
    else n_pass++;
    idle(5);
    ack = 1'b1;
    n_checks++;
    if (raise !== 1'b1) $display("FAIL ovr_raise_before_ack: got %b want 1", raise);
    else n_pass++;
    @(negedge clk);
    ack = 1'b0;
    n_checks++;
    if (raise !== 1'b0) $display("FAIL ovr_raise_after_ack: got %b want 0", raise);
    else n_pass++;
    bus_read(DATA_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL ovr_data_cleared: got %h want %h", v, e);
    else n_pass++;
    $display("overrun: cmd 3 then 5 without read");
  endtask

  task automatic test_bad_mark();
    logic [7:0] v, e;
    ir_in = 1'b0;
    idle(1400);
    ir_in = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    idle(LAT + 6);
    n_checks++;
    if (raise !== 1'b0) $display("FAIL bad_mark_raise: got %b want 0", raise);
    else n_pass++;
    bus_read(STAT_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL bad_mark_status: got %h want %h", v, e);
    else n_pass++;
    bus_write(STAT_ADDR, 8'hFF);
    bus_read(STAT_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL bad_mark_err_clear: got %h want %h", v, e);
    else n_pass++;
    $display("bad_mark: 1400 us start mark rejected");
  endtask

  task automatic test_timeout();
    logic [7:0] v, e;
    ir_in = 1'b0; idle(1600);
    ir_in = 1'b1; idle(100);
    ir_in = 1'b0; idle(800);
    ir_in = 1'b1; idle(100);
    ir_in = 1'b0; idle(400);
    ir_in = 1'b1;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    idle(2000);
    bus_read(STAT_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL timeout_busy: got %h want %h", v, e);
    else n_pass++;
    idle(1000);
    bus_read(STAT_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL timeout_err: got %h want %h", v, e);
    else n_pass++;
    n_checks++;
    if (raise !== 1'b0) $display("FAIL timeout_raise: got %b want 0", raise);
    else n_pass++;
    bus_write(STAT_ADDR, 8'h00);
    $display("timeout: 3000 us space after bit 1");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v, e;
    ir_in = 1'b0; idle(1600);
    ir_in = 1'b1; idle(100);
    ir_in = 1'b0; idle(400);
    ir_in = 1'b1; idle(100);
    ir_in = 1'b0; idle(800);
    ir_in = 1'b1; idle(100);
    ir_in = 1'b0; idle(200);
    rst_n = 1'b0;
    @(negedge clk);
    ir_in = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    n_checks++;
    if (raise !== 1'b0) $display("FAIL rst_mid_raise: got %b want 0", raise);
    else n_pass++;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    bus_read(STAT_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL rst_mid_status: got %h want %h", v, e);
    else n_pass++;
    bus_read(DATA_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL rst_mid_data: got %h want %h", v, e);
    else n_pass++;
    send_frame(4'h9, 1600, 800, 400, 100, -1);
    exp_q.push_back(8'h89);
    idle(LAT);
    n_checks++;
    if (raise !== 1'b1) $display("FAIL rst_mid_next_raise: got %b want 1", raise);
    else n_pass++;
    bus_read(DATA_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL rst_mid_next_data: got %h want %h", v, e);
    else n_pass++;
    pulse_ack();
    $display("reset_mid_frame: abort then cmd 9");
  endtask

  task automatic test_simultaneous();
    logic [7:0] v, e;
    send_frame(4'hA, 1600, 800, 400, 100, -1);
    idle(LAT - 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_checks++;
    if (raise !== 1'b1) $display("FAIL sim_ack_in_done: got %b want 1", raise);
    else n_pass++;
    idle(5);
    send_frame(4'h6, 1600, 800, 400, 100, -1);
    exp_q.push_back(8'h8A);
    exp_q.push_back(8'h86);
    idle(LAT - 1);
    bus_read(DATA_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL sim_read_in_done: got %h want %h", v, e);
    else n_pass++;
    bus_read(DATA_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL sim_new_frame_wins: got %h want %h", v, e);
    else n_pass++;
    pulse_ack();
    n_checks++;
    if (raise !== 1'b0) $display("FAIL sim_final_ack: got %b want 0", raise);
    else n_pass++;
    $display("simultaneous: ack and read in DONE cycle");
  endtask

  task automatic test_glitch();
    logic [7:0] v, e;
    send_frame(4'hC, 1600, 800, 400, 100, 2);
`ifdef IR_RECEIVER_GLITCH_FILTER_EN
    exp_q.push_back(8'h8C);
    idle(LAT);
    n_checks++;
    if (raise !== 1'b1) $display("FAIL glitch_raise: got %b want 1", raise);
    else n_pass++;
    bus_read(DATA_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL glitch_data: got %h want %h", v, e);
    else n_pass++;
    pulse_ack();
`else
    exp_q.push_back(8'h01);
    idle(LAT + 10);
    n_checks++;
    if (raise !== 1'b0) $display("FAIL glitch_raise: got %b want 0", raise);
    else n_pass++;
    bus_read(STAT_ADDR, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL glitch_status: got %h want %h", v, e);
    else n_pass++;
`endif
    $display("glitch: 1-cycle low pulse inside space of bit 2");
  endtask

  initial begin
    rst_n    = 1'b0;
    ir_in    = 1'b1;
    bus_addr = IDLE_ADDR;
    bus_we   = 1'b0;
    ack      = 1'b0;
    drv_en   = 1'b0;
    drv_val  = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    test_reset();
    test_valid_frame();
    test_overrun();
    test_bad_mark();
    test_timeout();
    test_reset_mid_frame();
    test_simultaneous();
    test_glitch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_receiver.md
# ir_receiver

Memory-mapped infrared command receiver for the 8-bit CPU bus. It is the receive-side counterpart of the IR transmitter peripheral. It samples a demodulated IR receiver input and times mark/space durations in microseconds. It decodes 4-bit car command frames, latches each decoded command into a bus-readable register and raises a CPU interrupt. It sits alongside the mouse and timer peripherals and takes one of the interrupt lines.

## Interface
Parameters:
- BASE_ADDR, 8'hB0: bus base address; DATA at BASE_ADDR, STATUS at BASE_ADDR+1
- CLK_PER_US, 50: CLK cycles per microsecond (50 MHz board clock)
- TIMEOUT_US, 2500: maximum space length inside a frame before the frame is aborted

Ports:
- CLK  in  1  system clock; the block is single-clock
- RESET  in  1  reset, asynchronous assert, active-low
- BUS_ADDR  in  8  CPU address bus
- BUS_DATA  inout  8  CPU data bus; driven only during a read response, high-Z otherwise
- BUS_WE  in  1  bus write enable
- IR_IN  in  1  demodulated IR input, asynchronous; low = carrier present (mark)
- BUS_INTERRUPT_RAISE  out  1  interrupt request to the CPU
- BUS_INTERRUPT_ACK  in  1  interrupt acknowledge from the CPU

## Operation
- **Input conditioning:** IR_IN passes through a 2-flop synchroniser (reset value 1) before any use.
- **Microsecond timer:**
  - A prescaler produces a 1 µs tick every CLK_PER_US cycles.
  - A 12-bit duration counter counts ticks and saturates at 4095.
  - The counter clears on every synchronised IR_IN edge.
- **Frame format:**
  - Start mark: 2000 µs. Accepted window: 1500–2500 µs.
  - Then 4 data marks, LSB first. A data mark of 1000 µs (750–1250) decodes as 1. A data mark of 500 µs (375–625) decodes as 0.
  - Every space inside the frame must be ≤ TIMEOUT_US.
- **FSM states:** IDLE, START_MARK, SPACE, DATA_MARK, DONE.
  - IDLE → START_MARK on a falling edge.
  - START_MARK → SPACE on a rising edge when the duration is in the start window. Otherwise → IDLE and set ERR.
  - SPACE → DATA_MARK on a falling edge. SPACE → IDLE and set ERR when the duration exceeds TIMEOUT_US.
  - DATA_MARK, on a rising edge:
    - Duration in the 0 or 1 window: shift the bit into the shift register.
    - That was bit 3: → DONE.
    - Bits remain: → SPACE.
    - Duration outside both windows: → IDLE and set ERR.
  - DONE lasts one cycle, then → IDLE. In DONE:
    - CMD ← the shift register.
    - If VALID was already 1, set OVR.
    - Set VALID.
    - Set BUS_INTERRUPT_RAISE.
- **DATA register (read):** {VALID, OVR, 2'b00, CMD[3:0]}. A read clears VALID and OVR.
- **STATUS register (read):** {5'b0, VALID, BUSY (FSM ≠ IDLE), ERR}. A write of any value clears ERR.
- Writes to DATA are ignored. Addresses other than BASE_ADDR and BASE_ADDR+1 are ignored.

## Timing
- **Reset values:**
  - BUS_INTERRUPT_RAISE = 0; BUS_DATA = Z.
  - CMD = 0; VALID = OVR = ERR = 0.
  - FSM = IDLE; counters = 0.
- **Read:** the address is sampled in cycle N with BUS_WE = 0. BUS_DATA is driven in cycle N+1 only. The read-clear side effect takes effect at the end of cycle N.
- **Decode latency:** BUS_INTERRUPT_RAISE rises 4 cycles after the IR_IN rising edge that ends bit 3. This is 2 synchroniser cycles, 1 edge-detect cycle and 1 DONE cycle.
- **Interrupt:** BUS_INTERRUPT_RAISE stays high until a cycle with BUS_INTERRUPT_ACK = 1, and is low from the next cycle.
- **Simultaneous events:**
  - DONE in the same cycle as ACK: RAISE stays 1.
  - DONE in the same cycle as a DATA read-clear: the new frame wins (VALID = 1, OVR = 0).
  - ERR set in the same cycle as an ERR-clearing write: ERR = 1.
- **Reset mid-frame:** asynchronous abort to IDLE. Partial bits are discarded and no interrupt is raised.

## Configuration
- IR_RECEIVER_GLITCH_FILTER_EN
  - **Defined:** a 3-sample majority filter follows the synchroniser. Edges shorter than 2 CLK cycles are rejected. Decode latency becomes 6 cycles.
  - **Undefined:** the synchroniser output is used directly, with 4-cycle latency.

## Structure
- Package ir_receiver_pkg holds:
  - the FSM state encoding;
  - register offsets (DATA_OFS = 0, STATUS_OFS = 1) and status bit positions;
  - the µs window limits: 1500/2500, 750/1250, 375/625.
- Sub-module ir_pulse_timer: synchroniser, optional filter, edge detect, prescaler and saturating µs counter. Its outputs are rise, fall and duration[11:0]. The FSM, registers and bus logic stay in ir_receiver.

## Test plan
- **Valid frame:** start 2000 µs, bits 1,0,1,1 (1000/500/1000/1000 µs marks, 500 µs spaces) → RAISE 4 cycles after the last rise; DATA read = 8'h8D; a second DATA read = 8'h0D.
- **Overrun:** two frames with CMD 4'h3 then 4'h5 and no read between them → DATA = 8'hC5; RAISE held until ACK, low the cycle after ACK.
- **Bad mark and timeout:** a 1400 µs start mark → no RAISE, STATUS = 8'h01, writing STATUS gives 8'h00. A separate 3000 µs space after bit 1 → ERR = 1 and BUSY = 0.
- **Reset mid-frame:** RESET low during bit 2 → FSM = IDLE, RAISE = 0, DATA = 8'h00, BUS_DATA = Z. A following full frame decodes correctly.
- **Simultaneous events:** ACK in the DONE cycle → RAISE = 1. A DATA read in the DONE cycle → VALID = 1.
- **Glitch filter:** with IR_RECEIVER_GLITCH_FILTER_EN defined, a 1-cycle low glitch inside a space is ignored and the frame decodes. Without it, the same glitch sets ERR.
